// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } arb_state_e;

  // Advance a round-robin pointer with an explicit wrap compare so that a
  // non-power-of-two requester count never relies on bit truncation.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned nreq);
    return (ptr >= nreq - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/uart_tx_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the pick.
module uart_tx_rr_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      cand = {1'b0, ptr_i} + (IDW+1)'(o);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (req_i[cand[IDW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_rr_arbiter.sv
// Shares one UART transmitter between NREQ producers, round-robin fair.
// Latency: 1 cycle from a request seen in IDLE to ack/tx_start.
// Backpressure: holds off grants while tx_busy is high; one frame in flight.
module uart_tx_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int W            = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*W-1:0]    req_data,
  output logic [NREQ-1:0]      ack,
  output logic [W-1:0]         tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                 busy
);

  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             start_q, start_d;
  logic [W-1:0]     data_q, data_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;

  uart_tx_rr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // Next-state and registered-output logic; ack/start are single-cycle pulses.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // A busy transmitter here is a leftover or foreign frame: never grant over it.
        if (!tx_busy && pick_any) begin
          data_d  = req_data[32'(pick_idx)*W +: W];
          grant_d = pick_idx;
          ack_d   = NREQ'(1) << pick_idx;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_d   = IDW'(next_ptr(32'(grant_q), NREQ));
        cnt_d   = '0;
        state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_d = WAIT_FALL;
        end else if (cnt_q == CNTW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged the start; treat the frame as done.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that drops any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Directed bench for uart_tx_rr_arbiter with a simple transmitter model.
// Latency: n/a.
// Backpressure: model raises tx_busy one cycle after start for FRAME cycles.
module tb_uart_tx_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 16;
  localparam int TOUT  = 4;
  localparam int FRAME = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [1:0]        grant_id;
  logic              busy;

  logic              mute;
  logic              force_busy;
  int                bcnt;
  int                checks   = 0;
  int                failures = 0;
  logic              prev_start = 1'b0;
  int                n;

  uart_tx_rr_arbiter #(
    .NREQ         (NREQ),
    .W            (W),
    .BUSY_TIMEOUT (TOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from the edge that samples tx_start, for FRAME cycles.
  always @(posedge clk) begin
    if (rst)                     bcnt <= 0;
    else if (tx_start && !mute)  bcnt <= FRAME;
    else if (bcnt != 0)          bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0) || force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Advance at least one cycle, then wait (bounded) for a start pulse.
  task automatic wait_start(input string tag);
    int m;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!tx_start && m < 60);
    check({tag, "_start"}, tx_start, 1);
  endtask

  task automatic wait_idle(input string tag);
    int m;
    m = 0;
    while (busy && m < 100) begin
      @(negedge clk);
      m++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic expect_grant(input string tag, input int k, input logic [W-1:0] word);
    check({tag, "_gid"}, grant_id, k);
    check({tag, "_data"}, tx_data, word);
    check({tag, "_ack"}, ack, 32'(1) << k);
  endtask

  // Cycle invariants: one-hot ack, ack coincides with start, no back-to-back starts.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("ack_onehot0", $onehot0(ack), 1);
      check("ack_with_start", |ack, tx_start);
      check("start_pair", tx_start && prev_start, 0);
    end
    prev_start = tx_start;
  end

  initial begin
    rst = 1'b1; req = '0; req_data = '0; mute = 1'b0; force_busy = 1'b0;
    tick(3);
    // Reset state
    check("rst_ack", ack, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_gid", grant_id, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // Single requester 2: start and ack in the cycle after the request is seen.
    req = 4'b0100; req_data[2*W +: W] = 16'hBEEF;
    tick(1);
    check("single_start", tx_start, 1);
    expect_grant("single", 2, 16'hBEEF);
    check("single_busy", busy, 1);
    req = '0;
    n = 0;
    while (tx_busy !== 1'b1 && n < 10) begin tick(1); n++; end
    while (tx_busy !== 1'b0 && n < 40) begin tick(1); n++; end
    check("single_tail", busy, 1);
    tick(1);
    check("single_done", busy, 0);
    check("single_hold", tx_data, 16'hBEEF);

    // Fairness and wrap: pointer now 3, so 3 wins over 0.
    req = 4'b1001; req_data[0 +: W] = 16'hA000; req_data[3*W +: W] = 16'hA003;
    wait_start("fair1");
    expect_grant("fair1", 3, 16'hA003);
    req = 4'b0001;
    wait_start("fair2");
    expect_grant("fair2", 0, 16'hA000);
    req = 4'b1000; req_data[3*W +: W] = 16'hA013;
    wait_start("fair3");
    expect_grant("fair3", 3, 16'hA013);
    req = 4'b1001; req_data[0 +: W] = 16'hA010;
    wait_start("fair4");
    expect_grant("fair4", 0, 16'hA010);
    req = '0;
    wait_idle("fair");

    // Busy at idle: no launch while tx_busy is held, launch one cycle after release.
    force_busy = 1'b1; req = 4'b0010; req_data[1*W +: W] = 16'h1111;
    n = 0;
    repeat (20) begin tick(1); if (tx_start) n++; end
    check("busyidle_nostart", n, 0);
    check("busyidle_state", busy, 0);
    force_busy = 1'b0;
    tick(1);
    check("busyidle_start", tx_start, 1);
    expect_grant("busyidle", 1, 16'h1111);
    req = '0;
    wait_idle("busyidle");

    // Timeout: transmitter silent, back to IDLE 1+TOUT cycles after launch.
    mute = 1'b1; req = 4'b0001; req_data[0 +: W] = 16'h7007;
    tick(1);
    check("tout_start", tx_start, 1);
    expect_grant("tout", 0, 16'h7007);
    req = '0;
    n = 0;
    while (busy && n < 20) begin tick(1); n++; end
    check("tout_cycles", n, 1 + TOUT);
    mute = 1'b0; req = 4'b0010; req_data[1*W +: W] = 16'h00C1;
    tick(1);
    check("tout_next_start", tx_start, 1);
    expect_grant("tout_next", 1, 16'h00C1);
    req = '0;
    wait_idle("tout_next");

    // Reset mid-frame while in WAIT_FALL.
    req = 4'b1000; req_data[3*W +: W] = 16'h5A5A;
    tick(1);
    expect_grant("midrst", 3, 16'h5A5A);
    req = '0;
    tick(3);
    check("midrst_inframe", busy & tx_busy, 1);
    rst = 1'b1; req = 4'b0100; req_data[2*W +: W] = 16'h0C0C;
    tick(1);
    check("midrst_ack", ack, 0);
    check("midrst_start", tx_start, 0);
    check("midrst_data", tx_data, 0);
    check("midrst_gid", grant_id, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    tick(1);
    check("midrst_regrant", tx_start, 1);
    expect_grant("midrst_regrant", 2, 16'h0C0C);
    req = '0;
    wait_idle("midrst");

    // Simultaneous requests from a fresh pointer: served 0,1,2,3 then round two at 0.
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) req_data[k*W +: W] = W'(k);
    for (int k = 0; k < NREQ; k++) begin
      wait_start("simul");
      expect_grant("simul", k, W'(k));
      req[k] = 1'b0;
    end
    wait_idle("simul");
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) req_data[k*W +: W] = W'(16'h0010 + k);
    wait_start("round2");
    expect_grant("round2", 0, 16'h0010);
    req = '0;
    wait_idle("round2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
